// File: rtl/phy_tx_scheduler.sv
// -----------------------------------------------------------------------------
// phy_tx_scheduler
//
// Purpose:
//   Byte-rate transmit scheduler in front of a parallel-to-serial PHY stage.
//   After reset it sends TRAIN_WORDS comma words (0xBC) and then raises
//   link_up. It then arbitrates between four requesters and grants bursts of
//   up to BURST_MAX words. Commas are sent whenever no requester data is
//   transferred. Every burst is followed by at least one comma bubble.
//
// Configuration macro:
//   TX_SCHED_ROUND_ROBIN_EN  defined   -> round-robin arbitration that
//                                         rotates a pointer on every grant
//                            undefined -> fixed priority, requester 0 highest
//
// Parameters:
//   TRAIN_WORDS  training comma words sent after reset (1..255)
//   BURST_MAX    maximum words accepted per grant (1..16)
//
// Ports:
//   clk_f      in   1   byte-rate clock; all logic uses the rising edge
//   reset      in   1   synchronous, active-high reset
//   req_valid  in   4   per-requester word valid (bit i = requester i)
//   req_data   in  32   requester i word in bits [8i+7:8i]
//   req_ready  out  4   per-requester accept; one-hot or zero
//   data_out   out  8   registered byte to the serializer
//   valid_out  out  1   registered; high when data_out carries requester data
//   grant_id   out  2   index of the current or most recent grantee
//   link_up    out  1   high once training is complete
// -----------------------------------------------------------------------------
module phy_tx_scheduler #(
    parameter int TRAIN_WORDS = 4,
    parameter int BURST_MAX   = 4
) (
    input  logic        clk_f,
    input  logic        reset,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    output logic [7:0]  data_out,
    output logic        valid_out,
    output logic [1:0]  grant_id,
    output logic        link_up
);

    localparam logic [7:0] COMMA      = 8'hBC;
    localparam logic [7:0] TRAIN_LAST = 8'(TRAIN_WORDS - 1);
    localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);

    typedef enum logic [1:0] {
        S_TRAIN = 2'd0,
        S_IDLE  = 2'd1,
        S_GRANT = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] train_cnt_q;
    logic [3:0] burst_cnt_q;
    logic [7:0] data_q;
    logic       valid_q;
    logic [1:0] grant_q;
    logic       link_q;
    logic [1:0] winner;
    logic       transfer;
    logic       burst_done;

`ifdef TX_SCHED_ROUND_ROBIN_EN
    logic [1:0] ptr_q;
`endif

    // A word moves only when the granted requester is valid while we are in
    // GRANT; other requesters' valid bits are ignored for the whole burst.
    assign transfer   = (state_q == S_GRANT) && req_valid[grant_q];
    assign burst_done = transfer && (burst_cnt_q == BURST_LAST);

    // Arbitration. The loop runs from the lowest-priority candidate to the
    // highest so that the last matching assignment is the winner.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        winner = 2'd0;
`ifdef TX_SCHED_ROUND_ROBIN_EN
        for (int k = 3; k >= 0; k--) begin
            if (req_valid[ptr_q + 2'(k)]) begin
                winner = ptr_q + 2'(k);
            end
        end
`else
        for (int k = 3; k >= 0; k--) begin
            if (req_valid[k]) begin
                winner = 2'(k);
            end
        end
`endif
    end

    // FSM: state register.
    always_ff @(posedge clk_f) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of process order.
        if (reset) begin
            state_q <= S_TRAIN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic. Leaving GRANT always lands in IDLE, which
    // produces the comma bubble between bursts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_TRAIN: if (train_cnt_q == TRAIN_LAST) state_d = S_IDLE;
            S_IDLE:  if (|req_valid)                state_d = S_GRANT;
            S_GRANT: if (!req_valid[grant_q] || burst_done) state_d = S_IDLE;
            default: state_d = S_TRAIN;
        endcase
    end

    // FSM: outputs. req_ready depends only on state and the registered grant.
    always_comb begin
        req_ready = 4'b0000;
        if (state_q == S_GRANT) begin
            req_ready = 4'b0001 << grant_q;
        end
    end

    // Datapath and counters. Reset overrides any word accepted in the same
    // cycle, so an interrupted burst never reaches data_out.
    always_ff @(posedge clk_f) begin
        if (reset) begin
            train_cnt_q <= 8'd0;
            burst_cnt_q <= 4'd0;
            data_q      <= COMMA;
            valid_q     <= 1'b0;
            grant_q     <= 2'd0;
            link_q      <= 1'b0;
`ifdef TX_SCHED_ROUND_ROBIN_EN
            ptr_q       <= 2'd0;
`endif
        end else begin
            data_q  <= transfer ? req_data[{grant_q, 3'b000} +: 8] : COMMA;
            valid_q <= transfer;

            if (state_q == S_TRAIN) begin
                train_cnt_q <= train_cnt_q + 8'd1;
                if (train_cnt_q == TRAIN_LAST) begin
                    link_q <= 1'b1;
                end
            end

            if ((state_q == S_IDLE) && (|req_valid)) begin
                grant_q     <= winner;
                burst_cnt_q <= 4'd0;
`ifdef TX_SCHED_ROUND_ROBIN_EN
                ptr_q       <= winner + 2'd1;
`endif
            end else if (transfer) begin
                burst_cnt_q <= burst_cnt_q + 4'd1;
            end
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign grant_id  = grant_q;
    assign link_up   = link_q;

endmodule

// File: tb/tb_phy_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_phy_tx_scheduler
//
// Directed bench for phy_tx_scheduler. Stimulus tasks push every expected
// requester word (grant id + byte) into a queue. A monitor pops and compares
// whenever valid_out is high. Control outputs (link_up, req_ready, commas)
// are checked directly by the stimulus at the falling edge.
// Round-robin expectations apply when TX_SCHED_ROUND_ROBIN_EN is defined.
// -----------------------------------------------------------------------------
module tb_phy_tx_scheduler;

    localparam int TRAIN_WORDS = 4;
    localparam int BURST_MAX   = 4;

    logic        clk_f = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  data_out;
    logic        valid_out;
    logic [1:0]  grant_id;
    logic        link_up;

    typedef struct packed {
        logic [1:0] gid;
        logic [7:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    phy_tx_scheduler #(
        .TRAIN_WORDS (TRAIN_WORDS),
        .BURST_MAX   (BURST_MAX)
    ) dut (
        .clk_f     (clk_f),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .data_out  (data_out),
        .valid_out (valid_out),
        .grant_id  (grant_id),
        .link_up   (link_up)
    );

    always #5 clk_f = ~clk_f;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every requester word on data_out must match the queue head.
    always @(negedge clk_f) begin : monitor
        beat_t e;
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: got data 0x%0h grant %0d, expected no beat (t=%0t)",
                         data_out, grant_id, $time);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", {24'h0, data_out}, {24'h0, e.data});
                check("beat_grant", {30'h0, grant_id}, {30'h0, e.gid});
            end
        end
    end

    // Inputs change 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge clk_f);
        #1;
    endtask

    // One reset cycle followed by the training period. On return the DUT is
    // at the start of its first IDLE cycle, unless chk is set, which also
    // consumes that cycle's falling edge to check link_up.
    task automatic reset_and_train(input bit chk);
        reset     = 1'b1;
        req_valid = 4'b0000;
        next_cycle();
        reset = 1'b0;
        for (int t = 0; t < TRAIN_WORDS; t++) begin
            if (chk) begin
                @(negedge clk_f);
                check("train_link",  {31'h0, link_up},   32'h0);
                check("train_data",  {24'h0, data_out},  32'hBC);
                check("train_valid", {31'h0, valid_out}, 32'h0);
                check("train_ready", {28'h0, req_ready}, 32'h0);
            end
            next_cycle();
        end
        if (chk) begin
            @(negedge clk_f);
            check("link_after_train", {31'h0, link_up},   32'h1);
            check("idle_data",        {24'h0, data_out},  32'hBC);
            check("idle_valid",       {31'h0, valid_out}, 32'h0);
        end
    endtask

    // Single short burst from requester 2, with lower-index requesters
    // toggling mid-burst; they must not disturb it.
    task automatic short_burst_test();
        logic [3:0] v_tab [6];
        logic [7:0] d_tab [6];
        logic       ev_tab[6];
        logic [3:0] rd_tab[6];
        v_tab  = '{4'b0100, 4'b0100, 4'b0101, 4'b0111, 4'b0000, 4'b0000};
        d_tab  = '{8'h11, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00};
        ev_tab = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        rd_tab = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        reset_and_train(1'b0);
        exp_q.push_back('{2'd2, 8'h11});
        exp_q.push_back('{2'd2, 8'h22});
        exp_q.push_back('{2'd2, 8'h33});
        for (int k = 0; k < 6; k++) begin
            req_valid = v_tab[k];
            req_data  = {8'h5A, d_tab[k], 8'hA5, 8'h3C};
            @(negedge clk_f);
            check("short_valid", {31'h0, valid_out}, {31'h0, ev_tab[k]});
            check("short_ready", {28'h0, req_ready}, {28'h0, rd_tab[k]});
            if (k >= 1) check("short_grant", {30'h0, grant_id}, 32'd2);
            next_cycle();
        end
        check("short_end_data", {24'h0, data_out}, 32'hBC);
    endtask

    // Continuous requests on mask for nbursts bursts. Burst b occupies cycles
    // 5b+1 .. 5b+4 (IDLE at 5b); requester i drives byte {i, k} in cycle k.
    task automatic run_bursts(input logic [3:0] mask, input int nbursts);
        int         grants[8];
        logic [1:0] ptr;
        bit         found;
        int         b;
        ptr = 2'd0;
        for (int n = 0; n < nbursts; n++) begin
            found = 1'b0;
`ifdef TX_SCHED_ROUND_ROBIN_EN
            for (int s = 0; s < 4; s++) begin
                if (!found && mask[(int'(ptr) + s) % 4]) begin
                    grants[n] = (int'(ptr) + s) % 4;
                    found = 1'b1;
                end
            end
            ptr = 2'(grants[n] + 1);
`else
            for (int s = 0; s < 4; s++) begin
                if (!found && mask[s]) begin
                    grants[n] = s;
                    found = 1'b1;
                end
            end
`endif
        end
        reset_and_train(1'b0);
        for (int k = 0; k <= 5 * nbursts + 2; k++) begin
            req_valid = (k < 5 * nbursts) ? mask : 4'b0000;
            for (int i = 0; i < 4; i++) req_data[8*i +: 8] = {2'(i), 6'(k)};
            if (k < 5 * nbursts && (k % 5) != 0) begin
                b = k / 5;
                exp_q.push_back('{2'(grants[b]), {2'(grants[b]), 6'(k)}});
            end
            @(negedge clk_f);
            // A word appears one cycle after each transfer cycle.
            check("burst_valid", {31'h0, valid_out},
                  {31'h0, ((k - 1) < 5 * nbursts && k >= 2 && ((k - 1) % 5) != 0)});
            if (k < 5 * nbursts && (k % 5) != 0)
                check("burst_ready", {28'h0, req_ready}, 32'(4'b0001 << grants[k / 5]));
            else
                check("burst_ready_idle", {28'h0, req_ready}, 32'h0);
            next_cycle();
        end
    endtask

    // Reset during a burst: words 1 and 2 out, word 3 abandoned, training
    // restarts with link_up low.
    task automatic reset_mid_burst_test();
        reset_and_train(1'b0);
        exp_q.push_back('{2'd0, 8'h41});
        exp_q.push_back('{2'd0, 8'h42});
        for (int k = 0; k <= 8; k++) begin
            reset     = (k == 3);
            req_valid = (k < 8) ? 4'b0001 : 4'b0000;
            req_data  = {24'h0, 8'h40 + 8'(k)};
            @(negedge clk_f);
            check("rst_valid", {31'h0, valid_out}, {31'h0, (k == 2 || k == 3)});
            if (k >= 4) begin
                check("rst_link",  {31'h0, link_up},   {31'h0, (k == 8)});
                check("rst_ready", {28'h0, req_ready}, 32'h0);
            end
            if (k == 4) check("rst_data", {24'h0, data_out}, 32'hBC);
            next_cycle();
        end
    endtask

    initial begin : stimulus
        reset     = 1'b1;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        next_cycle();

        reset_and_train(1'b1);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clk_f);
            check("link_stays_up", {31'h0, link_up},   32'h1);
            check("idle_comma",    {24'h0, data_out},  32'hBC);
            check("idle_ready",    {28'h0, req_ready}, 32'h0);
        end
        next_cycle();

        short_burst_test();
        run_bursts(4'b0001, 2);
        run_bursts(4'b0011, 4);
        run_bursts(4'b1100, 2);
        reset_mid_burst_test();

        check("queue_drained", exp_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/phy_tx_scheduler.md
PHY_TX_SCHEDULER -- requirements
Module: phy_tx_scheduler

Interface
REQ-001 Parameter TRAIN_WORDS, default 4, number of training comma words sent after reset (range 1..255).
REQ-002 Parameter BURST_MAX, default 4, maximum words accepted per grant (range 1..16).
REQ-003 clk_f  input  1  byte-rate clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  4  per-requester word-valid, bit i = requester i.
REQ-006 req_data  input  32  requester i data in bits [8i+7:8i].
REQ-007 req_ready  output  4  per-requester accept, one-hot or zero.
REQ-008 data_out  output  8  registered byte to parallel-to-serial stage.
REQ-009 valid_out  output  1  registered, high when data_out carries requester data.
REQ-010 grant_id  output  2  index of current/last grantee.
REQ-011 link_up  output  1  high once training complete.

Function
REQ-012 The block SHALL implement states TRAIN, IDLE, GRANT.
REQ-013 TRAIN SHALL last exactly TRAIN_WORDS cycles, driving data_out=0xBC, valid_out=0, req_ready=0, then enter IDLE and set link_up=1.
REQ-014 In IDLE, data_out SHALL be 0xBC, valid_out=0, req_ready=0.
REQ-015 In IDLE with any req_valid bit set, the block SHALL register the winner into grant_id and enter GRANT next cycle; with none set it SHALL remain IDLE.
REQ-016 In GRANT, req_ready SHALL be high only for bit grant_id (combinational from state).
REQ-017 A transfer SHALL occur when req_valid[g] and req_ready[g] are both high; the word SHALL appear on data_out with valid_out=1 the following cycle (latency 1).
REQ-018 A GRANT cycle without transfer SHALL output data_out=0xBC, valid_out=0 next cycle.
REQ-019 A 4-bit burst counter SHALL clear on GRANT entry and increment per transfer.
REQ-020 GRANT SHALL exit to IDLE after the transfer that makes the count equal BURST_MAX, or in any GRANT cycle where req_valid[g]=0 (no transfer that cycle).
REQ-021 Every GRANT exit SHALL pass through at least one IDLE cycle (one comma bubble between bursts).
REQ-022 req_valid changes on non-granted requesters SHALL not affect the current burst.
REQ-023 link_up SHALL stay high until reset.

Reset
REQ-024 On reset high at a clock edge: state=TRAIN, training counter=0, burst counter=0, data_out=0xBC, valid_out=0, req_ready=0, grant_id=0, link_up=0, arbitration pointer=0.
REQ-025 Reset asserted mid-burst SHALL abandon the burst; no word accepted in the reset cycle is output.

Configuration
REQ-026 Macro TX_SCHED_ROUND_ROBIN_EN defined: winner SHALL be the first requesting index searching upward (mod 4) from pointer; pointer SHALL become grant_id+1 mod 4 on each GRANT entry.
REQ-027 Macro undefined: winner SHALL be the lowest requesting index (fixed priority, 0 highest); pointer logic absent.

Verification
REQ-028 Reset 1 cycle, no requests -> 4 cycles data_out=0xBC/link_up=0, then link_up=1, data_out stays 0xBC, valid_out=0.
REQ-029 After link_up, req 2 valid with 0x11,0x22,0x33 then drops -> grant_id=2, data_out 0x11,0x22,0x33 with valid_out=1 on consecutive cycles, then 0xBC/valid_out=0, state IDLE.
REQ-030 Req 0 continuously valid, BURST_MAX=4 -> exactly 4 words out, one 0xBC bubble, next burst of 4.
REQ-031 Reqs 0 and 1 continuously valid, macro defined -> bursts alternate 0,1,0,1; macro undefined -> only requester 0 served.
REQ-032 Reset asserted after 2nd word of a burst -> next cycle valid_out=0, data_out=0xBC, link_up=0, TRAIN restarts, req_ready=0.
